// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared FSM states and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;
    typedef enum logic [1:0] {RUN, MEM_WAIT, MEM_ERR} state_t;
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int DEF_MEM_TIMEOUT = 15;
endpackage

// File: rtl/pipe_hazard_detect.sv
// pipe_hazard_detect: combinational load-use comparator between the load in EX and the sources in ID.
module pipe_hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic       i_ex_load,
    input  logic       i_ex_reg_write,
    input  logic [4:0] i_ex_wb_addr,
    output logic       o_load_use
);
    assign o_load_use = i_ex_load & i_ex_reg_write & (i_ex_wb_addr != REG_ZERO) &
                        ((i_ex_wb_addr == i_id_rs) | (i_ex_wb_addr == i_id_rt));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller for load-use, taken branches and multi-cycle data memory.
// Define PIPE_HAZARD_CTRL_PERF_EN to add the StallCount/FlushCount performance counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int CNT_W       = 32
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             EX_Mem2RegSEL,
    input  logic             EX_RegWriteEN,
    input  logic [4:0]       EX_WriteBackRegAddr,
    input  logic             MEM_Branch,
    input  logic             MEM_ZeroFlag,
    input  logic             MEM_MemAccess,
    input  logic             DMEM_Ready,
    output logic             DMEM_Req,
    output logic             PC_WriteEN,
    output logic             IF_ID_WriteEN,
    output logic             ID_EX_WriteEN,
    output logic             EX_MEM_WriteEN,
    output logic             MEM_WB_WriteEN,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Flush,
    output logic             PC_BranchSEL,
    output logic             Bus_Error
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
`endif
);
    localparam logic [7:0] LP_TIMEOUT = 8'(MEM_TIMEOUT);

    state_t     r_state, w_next;
    logic [7:0] r_wait_cnt, w_wait_next, w_cnt_inc;
    logic       w_load_use, w_taken, w_hold;

    pipe_hazard_detect u_detect (
        .i_id_rs        (ID_Rs),
        .i_id_rt        (ID_Rt),
        .i_ex_load      (EX_Mem2RegSEL),
        .i_ex_reg_write (EX_RegWriteEN),
        .i_ex_wb_addr   (EX_WriteBackRegAddr),
        .o_load_use     (w_load_use)
    );

    assign w_taken   = MEM_Branch & MEM_ZeroFlag;
    assign w_cnt_inc = (r_wait_cnt == 8'hFF) ? r_wait_cnt : r_wait_cnt + 8'd1;
    // Freeze the whole pipeline while memory is busy or after a bus error
    assign w_hold    = (r_state == MEM_ERR) | (~DMEM_Ready & ((r_state == MEM_WAIT) | MEM_MemAccess));

    always_comb begin
        w_next      = r_state;
        w_wait_next = r_wait_cnt;
        unique case (r_state)
            RUN: begin
                w_next      = (MEM_MemAccess & ~DMEM_Ready) ? MEM_WAIT : RUN;
                w_wait_next = (MEM_MemAccess & ~DMEM_Ready) ? 8'd1 : r_wait_cnt;
            end
            MEM_WAIT: begin
                w_next      = DMEM_Ready ? RUN : (w_cnt_inc >= LP_TIMEOUT) ? MEM_ERR : MEM_WAIT;
                w_wait_next = DMEM_Ready ? 8'd0 : w_cnt_inc;
            end
            MEM_ERR: w_next = MEM_ERR;
            default: w_next = RUN;
        endcase
        DMEM_Req       = (r_state == MEM_WAIT) | ((r_state == RUN) & MEM_MemAccess);
        PC_WriteEN     = ~w_hold & ~(w_load_use & ~w_taken);
        IF_ID_WriteEN  = ~w_hold & ~(w_load_use & ~w_taken);
        ID_EX_WriteEN  = ~w_hold;
        EX_MEM_WriteEN = ~w_hold;
        MEM_WB_WriteEN = ~w_hold;
        IF_ID_Flush    = ~w_hold & w_taken;
        ID_EX_Flush    = ~w_hold & (w_taken | w_load_use);
        EX_MEM_Flush   = ~w_hold & w_taken;
        PC_BranchSEL   = ~w_hold & w_taken;
        Bus_Error      = (r_state == MEM_ERR);
        if (RESET) begin
            w_next         = RUN;
            w_wait_next    = 8'd0;
            DMEM_Req       = 1'b0;
            PC_WriteEN     = 1'b1;
            IF_ID_WriteEN  = 1'b1;
            ID_EX_WriteEN  = 1'b1;
            EX_MEM_WriteEN = 1'b1;
            MEM_WB_WriteEN = 1'b1;
            IF_ID_Flush    = 1'b1;
            ID_EX_Flush    = 1'b1;
            EX_MEM_Flush   = 1'b1;
            PC_BranchSEL   = 1'b0;
            Bus_Error      = 1'b0;
        end
    end

    always_ff @(posedge CLOCK) begin
        r_state    <= w_next;
        r_wait_cnt <= w_wait_next;
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (!PC_WriteEN) StallCount <= StallCount + 1'b1;
            if (PC_BranchSEL) FlushCount <= FlushCount + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and random checks of pipe_hazard_ctrl against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;
    localparam int TO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, ld, wr, br, zf, ma, rdy;
    logic [4:0] rs, rt, wb;
    logic       req, pc_we, ifid_we, idex_we, exmem_we, memwb_we;
    logic       f_ifid, f_idex, f_exmem, sel, berr;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int checks = 0, errors = 0;
    bit m_wait, m_err;
    int m_elapsed;
    int unsigned m_stalls, m_flushes;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
        .CLOCK(clk), .RESET(rst), .ID_Rs(rs), .ID_Rt(rt),
        .EX_Mem2RegSEL(ld), .EX_RegWriteEN(wr), .EX_WriteBackRegAddr(wb),
        .MEM_Branch(br), .MEM_ZeroFlag(zf), .MEM_MemAccess(ma), .DMEM_Ready(rdy),
        .DMEM_Req(req), .PC_WriteEN(pc_we), .IF_ID_WriteEN(ifid_we), .ID_EX_WriteEN(idex_we),
        .EX_MEM_WriteEN(exmem_we), .MEM_WB_WriteEN(memwb_we), .IF_ID_Flush(f_ifid),
        .ID_EX_Flush(f_idex), .EX_MEM_Flush(f_exmem), .PC_BranchSEL(sel), .Bus_Error(berr)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        , .StallCount(stall_cnt), .FlushCount(flush_cnt)
`endif
    );

    // {req, pc, ifid, idex, exmem, memwb, f_ifid, f_idex, f_exmem, sel, berr}
    function automatic logic [10:0] model_out();
        logic taken, lu, frozen, q;
        taken  = br & zf;
        lu     = ld & wr & (wb != 0) & (wb == rs || wb == rt);
        frozen = m_wait ? !rdy : (ma && !rdy);
        q      = m_wait | ma;
        if (rst)    return 11'b0_11111_111_0_0;
        if (m_err)  return 11'b0_00000_000_0_1;
        if (frozen) return 11'b1_00000_000_0_0;
        if (taken)  return {q, 10'b11111_111_1_0};
        if (lu)     return {q, 10'b00111_010_0_0};
        return {q, 10'b11111_000_0_0};
    endfunction

    task automatic check(input string tag);
        logic [10:0] got, exp;
        #1;
        exp = model_out();
        got = {req, pc_we, ifid_we, idex_we, exmem_we, memwb_we, f_ifid, f_idex, f_exmem, sel, berr};
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s outputs got=%b expected=%b", tag, got, exp);
        end
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        checks++;
        assert ({stall_cnt, flush_cnt} === {m_stalls, m_flushes}) else begin
            errors++;
            $error("FAIL %s counters got=%0d/%0d expected=%0d/%0d", tag, stall_cnt, flush_cnt, m_stalls, m_flushes);
        end
`endif
    endtask

    task automatic model_step();
        logic [10:0] e;
        logic frozen;
        e = model_out();
        frozen = m_wait ? !rdy : (ma && !rdy);
        if (rst) begin
            {m_wait, m_err, m_elapsed, m_stalls, m_flushes} = '0;
        end else begin
            if (!e[9]) m_stalls++;
            if (e[1]) m_flushes++;
            if (!m_err) begin
                if (!frozen) m_wait = 0;
                else if (!m_wait) begin
                    m_wait = 1;
                    m_elapsed = 1;
                end else begin
                    m_elapsed++;
                    if (m_elapsed >= TO) begin
                        m_err = 1;
                        m_wait = 0;
                    end
                end
            end
        end
    endtask

    task automatic cyc(input logic r, input logic [4:0] s, t, input logic l, w, input logic [4:0] d,
                       input logic b, z, m, y, input string tag);
        @(negedge clk);
        {rst, rs, rt, ld, wr, wb, br, zf, ma, rdy} = {r, s, t, l, w, d, b, z, m, y};
        check(tag);
        @(posedge clk);
        model_step();
    endtask

    initial begin
        {rst, rs, rt, ld, wr, wb, br, zf, ma, rdy} = '0;
        rst = 1'b1;
        {m_wait, m_err, m_elapsed, m_stalls, m_flushes} = '0;
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset0");
        cyc(1, 8, 8, 1, 1, 8, 1, 1, 1, 0, "reset1");
        cyc(0, 8, 0, 1, 1, 8, 0, 0, 0, 1, "lu_rs");
        cyc(0, 8, 0, 0, 0, 0, 0, 0, 0, 1, "lu_clear");
        cyc(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, "lu_r0");
        cyc(0, 3, 9, 1, 1, 9, 0, 0, 0, 1, "lu_rt");
        cyc(0, 3, 9, 0, 1, 9, 0, 0, 0, 1, "no_load");
        cyc(0, 8, 0, 1, 1, 8, 1, 1, 0, 1, "br_lu");
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, "br_nt");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, "mem_zero_wait");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "after_zw");
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "mem_wait");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, "mem_ready");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "after_wait");
        for (int i = 0; i < TO; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "to_wait");
        for (int i = 0; i < 3; i++) cyc(0, 8, 0, 1, 1, 8, 1, 1, 0, 1, "err_hold");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "err_reset");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "post_err_reset");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "mid_w1");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "mid_w2");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, "mid_reset");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "mid_after");
        for (int i = 0; i < TO - 1; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "cnt_cleared");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, "cnt_ready");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "perf_reset");
        cyc(0, 5, 0, 1, 1, 5, 0, 0, 0, 1, "perf_lu");
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "perf_wait");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, "perf_ready");
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, "perf_branch");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "perf_end");
        for (int i = 0; i < 500; i++)
            cyc($urandom_range(0, 49) == 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                $urandom_range(0, 3) == 0, 1'($urandom), $urandom_range(0, 3) == 0,
                $urandom_range(0, 4) != 0, "random");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
